// File: rtl/cam_pkg.sv
// Shared types, widths and heading arithmetic for the camera pose controller.
package cam_pkg;

    localparam int unsigned ANGLE_MOD = 360;
    localparam int unsigned ANGLE_W   = 16;
    localparam int unsigned ANGLE_XW  = ANGLE_W + 1;
    localparam int unsigned COORD_W   = 16;
    localparam int unsigned HCOUNT_W  = 11;
    localparam int unsigned VCOUNT_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } cam_state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_POS,
        DIR_NEG
    } cam_dir_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } ball_pos_t;

    // One heading step with wrap into 0..ANGLE_MOD-1; assumes angle and step are already < ANGLE_MOD.
    function automatic logic [ANGLE_W-1:0] wrap_step(
        input logic [ANGLE_W-1:0] angle,
        input logic [ANGLE_W-1:0] step,
        input cam_dir_t           dir
    );
        logic [ANGLE_XW-1:0] sum;
        sum       = {1'b0, angle} + {1'b0, step};
        wrap_step = angle;
        case (dir)
            DIR_POS: begin
                if (sum >= ANGLE_XW'(ANGLE_MOD)) begin
                    wrap_step = ANGLE_W'(sum - ANGLE_XW'(ANGLE_MOD));
                end else begin
                    wrap_step = ANGLE_W'(sum);
                end
            end
            DIR_NEG: begin
                if (angle < step) begin
                    wrap_step = ANGLE_W'(({1'b0, angle} + ANGLE_XW'(ANGLE_MOD)) - {1'b0, step});
                end else begin
                    wrap_step = angle - step;
                end
            end
            default: wrap_step = angle;
        endcase
    endfunction

endpackage

// File: rtl/hold_repeat_timer.sv
// Press / hold / auto-repeat sequencer: immediate step on press, one after INIT_DELAY,
// then one every REPEAT_CYCLES while the same direction stays held.
module hold_repeat_timer
    import cam_pkg::*;
#(
    parameter int unsigned INIT_DELAY    = 2000000,
    parameter int unsigned REPEAT_CYCLES = 100000
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  cam_dir_t i_dir,
    input  logic     i_clear,
    output logic     o_step_c,
    output cam_dir_t o_step_dir_c
);

    localparam int unsigned MAX_CNT = (INIT_DELAY > REPEAT_CYCLES) ? INIT_DELAY : REPEAT_CYCLES;
    localparam int unsigned TIMER_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    if (INIT_DELAY < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
        $error("hold_repeat_timer: INIT_DELAY and REPEAT_CYCLES must be >= 1");
    end

    cam_state_t           r_state;
    cam_state_t           w_state_nxt;
    cam_dir_t             r_dir;
    cam_dir_t             w_dir_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_dir   <= DIR_NONE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Release/clear wins, then a new or reversed press restarts the sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_timer_nxt  = r_timer;
        o_step_c     = 1'b0;
        o_step_dir_c = DIR_NONE;

        if (i_clear || i_dir == DIR_NONE) begin
            w_state_nxt = IDLE;
            w_dir_nxt   = DIR_NONE;
            w_timer_nxt = '0;
        end else if (r_state == IDLE || i_dir != r_dir) begin
            o_step_c     = 1'b1;
            o_step_dir_c = i_dir;
            w_state_nxt  = DELAY;
            w_dir_nxt    = i_dir;
            w_timer_nxt  = '0;
        end else begin
            case (r_state)
                DELAY: begin
                    if (r_timer == TIMER_W'(INIT_DELAY - 1)) begin
                        o_step_c     = 1'b1;
                        o_step_dir_c = i_dir;
                        w_state_nxt  = REPEAT;
                        w_timer_nxt  = '0;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                REPEAT: begin
                    if (r_timer == TIMER_W'(REPEAT_CYCLES - 1)) begin
                        o_step_c     = 1'b1;
                        o_step_dir_c = i_dir;
                        w_timer_nxt  = '0;
                    end else begin
                        w_timer_nxt = r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/camera_pose_ctrl.sv
// Heading/ball pose staging for the map renderer, published once per frame at (0, LATCH_LINE).
// Optional CAM_RECENTER_EN adds recenter_in to snap the heading back to DEFAULT_ANGLE.
module camera_pose_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned STEP_DEG      = 1,
    parameter int unsigned INIT_DELAY    = 2000000,
    parameter int unsigned REPEAT_CYCLES = 100000,
    parameter int unsigned LATCH_LINE    = 720,
    parameter int unsigned DEFAULT_ANGLE = 90
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                rot_left_in,
    input  logic                rot_right_in,
`ifdef CAM_RECENTER_EN
    input  logic                recenter_in,
`endif
    input  logic                ball_valid_in,
    input  logic [COORD_W-1:0]  ball_x_in,
    input  logic [COORD_W-1:0]  ball_y_in,
    output logic [ANGLE_W-1:0]  angle_out,
    output logic [COORD_W-1:0]  ballx_out,
    output logic [COORD_W-1:0]  bally_out,
    output logic                frame_latch_out
);

    if (STEP_DEG >= ANGLE_MOD) begin : g_bad_step
        $error("camera_pose_ctrl: STEP_DEG must be < 360");
    end
    if (DEFAULT_ANGLE >= ANGLE_MOD) begin : g_bad_default
        $error("camera_pose_ctrl: DEFAULT_ANGLE must be < 360");
    end

    cam_dir_t            w_dir;
    cam_dir_t            w_step_dir;
    logic                w_step;
    logic                w_recenter;
    logic                w_latch;

    logic [ANGLE_W-1:0]  r_pending_angle;
    ball_pos_t           r_pending_ball;
    logic [ANGLE_W-1:0]  r_angle;
    ball_pos_t           r_ball;
    logic                r_frame_latch;

`ifdef CAM_RECENTER_EN
    assign w_recenter = recenter_in;
`else
    assign w_recenter = 1'b0;
`endif

    // Both buttons together cancel out.
    always_comb begin
        w_dir = DIR_NONE;
        if (rot_left_in && !rot_right_in) begin
            w_dir = DIR_POS;
        end else if (rot_right_in && !rot_left_in) begin
            w_dir = DIR_NEG;
        end
    end

    assign w_latch = (hcount_in == '0) && (vcount_in == VCOUNT_W'(LATCH_LINE));

    hold_repeat_timer #(
        .INIT_DELAY    (INIT_DELAY),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_hold_repeat_timer (
        .i_clk        (pixel_clk_in),
        .i_rst_n      (rst_in),
        .i_dir        (w_dir),
        .i_clear      (w_recenter),
        .o_step_c     (w_step),
        .o_step_dir_c (w_step_dir)
    );

    // Latch reads the pre-update pending values, so same-cycle changes land next frame.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            r_pending_angle <= ANGLE_W'(DEFAULT_ANGLE);
            r_pending_ball  <= '0;
            r_angle         <= ANGLE_W'(DEFAULT_ANGLE);
            r_ball          <= '0;
            r_frame_latch   <= 1'b0;
        end else begin
            if (w_recenter) begin
                r_pending_angle <= ANGLE_W'(DEFAULT_ANGLE);
            end else if (w_step) begin
                r_pending_angle <= wrap_step(r_pending_angle, ANGLE_W'(STEP_DEG), w_step_dir);
            end
            if (ball_valid_in) begin
                r_pending_ball <= '{x: ball_x_in, y: ball_y_in};
            end
            if (w_latch) begin
                r_angle <= r_pending_angle;
                r_ball  <= r_pending_ball;
            end
            r_frame_latch <= w_latch;
        end
    end

    assign angle_out       = r_angle;
    assign ballx_out       = r_ball.x;
    assign bally_out       = r_ball.y;
    assign frame_latch_out = r_frame_latch;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// Directed bench for camera_pose_ctrl on a shrunken raster (16 x 21, latch line 18).
module tb_camera_pose_ctrl;

    localparam int unsigned H_TOTAL = 16;
    localparam int unsigned V_TOTAL = 21;
    localparam int unsigned LATCH   = 18;
    localparam int unsigned FRAME   = H_TOTAL * V_TOTAL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        rot_l, rot_r, rot_l_b, rot_r_c, tie0;
    logic        recenter;
    logic        ball_valid;
    logic [15:0] ball_x, ball_y;

    logic [15:0] angle_a, ballx_a, bally_a;
    logic [15:0] angle_b, ballx_b, bally_b;
    logic [15:0] angle_c, ballx_c, bally_c;
    logic        fl_a, fl_b, fl_c;

    int   tests = 0;
    int   fails = 0;
    int   pulses;
    int   misal;
    logic latch_prev;
    logic seen;

    always #5 clk = ~clk;

    camera_pose_ctrl #(.STEP_DEG(1), .INIT_DELAY(10), .REPEAT_CYCLES(4),
                       .LATCH_LINE(LATCH), .DEFAULT_ANGLE(90)) dut_a (
        .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .rot_left_in(rot_l), .rot_right_in(rot_r),
`ifdef CAM_RECENTER_EN
        .recenter_in(recenter),
`endif
        .ball_valid_in(ball_valid), .ball_x_in(ball_x), .ball_y_in(ball_y),
        .angle_out(angle_a), .ballx_out(ballx_a), .bally_out(bally_a), .frame_latch_out(fl_a));

    camera_pose_ctrl #(.STEP_DEG(1), .INIT_DELAY(10), .REPEAT_CYCLES(4),
                       .LATCH_LINE(LATCH), .DEFAULT_ANGLE(359)) dut_b (
        .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .rot_left_in(rot_l_b), .rot_right_in(tie0),
`ifdef CAM_RECENTER_EN
        .recenter_in(tie0),
`endif
        .ball_valid_in(tie0), .ball_x_in(ball_x), .ball_y_in(ball_y),
        .angle_out(angle_b), .ballx_out(ballx_b), .bally_out(bally_b), .frame_latch_out(fl_b));

    camera_pose_ctrl #(.STEP_DEG(1), .INIT_DELAY(10), .REPEAT_CYCLES(4),
                       .LATCH_LINE(LATCH), .DEFAULT_ANGLE(0)) dut_c (
        .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .rot_left_in(tie0), .rot_right_in(rot_r_c),
`ifdef CAM_RECENTER_EN
        .recenter_in(tie0),
`endif
        .ball_valid_in(tie0), .ball_x_in(ball_x), .ball_y_in(ball_y),
        .angle_out(angle_c), .ballx_out(ballx_c), .bally_out(bally_c), .frame_latch_out(fl_c));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: remember whether this edge was the latch point, then advance the raster.
    task automatic tick();
        @(posedge clk);
        latch_prev = (hcount == 11'd0) && (vcount == 10'(LATCH));
        #1;
        if (hcount == 11'(H_TOTAL - 1)) begin
            hcount = 11'd0;
            vcount = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
    endtask

    task automatic run_to_latch(input string tag);
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick();
            seen = (fl_a === 1'b1);
        end
        check({tag, "_latch_seen"}, 16'(seen), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; rot_l = 1'b0; rot_r = 1'b0; rot_l_b = 1'b0; rot_r_c = 1'b0;
        tie0 = 1'b0; recenter = 1'b0; ball_valid = 1'b0; ball_x = '0; ball_y = '0;
        hcount = '0; vcount = '0; latch_prev = 1'b0;

        repeat (3) tick();
        check("rst_angle_a", angle_a, 16'd90);
        check("rst_ballx",   ballx_a, 16'd0);
        check("rst_bally",   bally_a, 16'd0);
        check("rst_fl",      16'(fl_a), 16'd0);
        check("rst_angle_b", angle_b, 16'd359);
        check("rst_angle_c", angle_c, 16'd0);

        rst_n = 1'b1;
        pulses = 0; misal = 0;
        repeat (2 * FRAME) begin
            tick();
            if (fl_a === 1'b1) pulses++;
            if (fl_a !== latch_prev) misal++;
        end
        check("fl_pulses_2frames", 16'(pulses), 16'd2);
        check("fl_alignment",      16'(misal),  16'd0);
        check("idle_angle",        angle_a, 16'd90);
        check("idle_ballx",        ballx_a, 16'd0);

        // Hold left 30 cycles: steps at 0,10,14,18,22,26; taps on the wrap instances.
        run_to_latch("sync0");
        rot_l = 1'b1; rot_l_b = 1'b1; rot_r_c = 1'b1;
        tick();
        rot_l_b = 1'b0; rot_r_c = 1'b0;
        repeat (29) tick();
        rot_l = 1'b0;
        check("hold_midframe_stable", angle_a, 16'd90);
        run_to_latch("hold");
        check("hold_angle_96",     angle_a, 16'd96);
        check("wrap_359_plus",     angle_b, 16'd0);
        check("wrap_0_minus",      angle_c, 16'd359);

        // Direct reversal: +1, then fresh right press -1 and a delayed -1.
        rot_l = 1'b1;
        repeat (3) tick();
        rot_l = 1'b0; rot_r = 1'b1;
        repeat (11) tick();
        rot_r = 1'b0;
        tick();
        run_to_latch("rev");
        check("reverse_angle_95", angle_a, 16'd95);

        // Left 5 (+1), both 20 (none), right-only 12 (-2).
        rot_l = 1'b1;
        repeat (5) tick();
        rot_r = 1'b1;
        repeat (20) tick();
        rot_l = 1'b0;
        repeat (12) tick();
        rot_r = 1'b0;
        tick();
        run_to_latch("both");
        check("both_then_right_94", angle_a, 16'd94);

        // Mid-frame ball capture shows only after the latch.
        ball_valid = 1'b1; ball_x = 16'h00AA; ball_y = 16'h00BB;
        tick();
        ball_valid = 1'b0;
        check("ball_midframe_hold", ballx_a, 16'd0);
        run_to_latch("ball1");
        check("ball_x_aa", ballx_a, 16'h00AA);
        check("ball_y_bb", bally_a, 16'h00BB);

        // Ball strobe on the latch edge itself waits a full frame.
        for (int i = 0; i < 2 * FRAME && !(hcount == 11'd0 && vcount == 10'(LATCH)); i++) tick();
        ball_valid = 1'b1; ball_x = 16'h1234; ball_y = 16'h0567;
        tick();
        ball_valid = 1'b0;
        check("edge_fl_pulse",  16'(fl_a), 16'd1);
        check("edge_ballx_old", ballx_a, 16'h00AA);
        check("edge_bally_old", bally_a, 16'h00BB);
        run_to_latch("ball2");
        check("edge_ballx_new", ballx_a, 16'h1234);
        check("edge_bally_new", bally_a, 16'h0567);

`ifdef CAM_RECENTER_EN
        // 427 held cycles = 106 steps: 94 -> 200, then recenter beats a same-cycle step.
        rot_l = 1'b1;
        repeat (427) tick();
        rot_l = 1'b0;
        tick();
        run_to_latch("rc_pre");
        check("recenter_pre_200", angle_a, 16'd200);
        rot_l = 1'b1; recenter = 1'b1;
        tick();
        rot_l = 1'b0; recenter = 1'b0;
        run_to_latch("rc");
        check("recenter_90", angle_a, 16'd90);
`endif

        // Reset mid-hold: FSM returns to IDLE, so a still-held button steps at release.
        rot_l = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check("midhold_rst_angle", angle_a, 16'd90);
        check("midhold_rst_ballx", ballx_a, 16'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        rot_l = 1'b0;
        run_to_latch("post_rst");
        check("post_rst_angle_91", angle_a, 16'd91);
        check("post_rst_angle_b",  angle_b, 16'd359);
        check("post_rst_angle_c",  angle_c, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
